count_extender: RTL and testbench

Downstream consumer of the 4-bit serial-carry counter. It samples the counter's `out[3:0]` on the rising edge of the shared clock and detects each 15→0 wrap. The wraps drive an upper extension counter, giving a wider monotonic count. The block also flags illegal count sequences, raises a compare-match pulse, and offers a valid/ready snapshot port to a consumer.

---
 rtl/count_pkg.sv | 16 +
 rtl/count_step_check.sv | 36 +++
 rtl/count_extender.sv | 144 ++++++++++++++
 tb/tb_count_extender.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and widths for the counter extension slice.
package count_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HOLD = 1'b1
  } cap_state_e;

  // Total extended count width for a given extension width.
  function automatic int unsigned total_w(input int unsigned ext_w);
    return CNT_W + ext_w;
  endfunction

endpackage

// File: rtl/count_step_check.sv
// Classifies the step between the registered and incoming upstream count.
module count_step_check
  import count_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_q,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             hold,
  output logic             step,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    hold    = 1'b0;
    step    = 1'b0;
    wrap    = 1'b0;
    illegal = 1'b0;
    if (cnt_in == cnt_q) begin
      hold = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      // From the top value only a return to zero is legal.
      if (cnt_in == '0) begin
        wrap = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else if (cnt_in == cnt_q + CNT_W'(1)) begin
      step = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/count_extender.sv
// Extends the upstream 4-bit count with wrap counting, compare match and snapshot port.
// Build option: COUNT_EXT_OVF_STICKY_EN makes ovf sticky until reset or clr.
module count_extender
  import count_pkg::*;
#(
  parameter  int unsigned EXT_W = 4,
  localparam int unsigned TW    = total_w(EXT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic [TW-1:0]    cmp_val,
  output logic [TW-1:0]    ext_cnt,
  output logic             wrap,
  output logic             match,
  output logic             ovf,
  output logic             seq_err,
  input  logic             cap_req,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [TW-1:0]    cap_data
);

  localparam logic [EXT_W-1:0] EXT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [EXT_W-1:0] ext_hi;
  logic [EXT_W-1:0] ext_hi_nxt;
  logic             primed;
  logic             eq_q;
  logic             eq_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic             err_nxt;
  logic             st_hold;
  logic             st_step;
  logic             st_wrap;
  logic             st_illegal;
  logic             bad_step;

  cap_state_e       cap_state;
  cap_state_e       cap_state_nxt;
  logic [TW-1:0]    cap_data_nxt;

  count_step_check u_step (
    .cnt_q   (cnt_q),
    .cnt_in  (cnt_in),
    .hold    (st_hold),
    .step    (st_step),
    .wrap    (st_wrap),
    .illegal (st_illegal)
  );

  // A step matching no legal class is treated as illegal as well.
  assign bad_step = st_illegal | ~(st_hold | st_step | st_wrap);

  // Extension, overflow, error and equality next-state.
  always_comb begin
    ext_hi_nxt = ext_hi;
    wrap_nxt   = 1'b0;
`ifdef COUNT_EXT_OVF_STICKY_EN
    ovf_nxt    = ovf;
`else
    ovf_nxt    = 1'b0;
`endif
    err_nxt    = seq_err;
    if (clr) begin
      ext_hi_nxt = '0;
      ovf_nxt    = 1'b0;
      err_nxt    = 1'b0;
    end else if (primed) begin
      if (st_wrap) begin
        ext_hi_nxt = ext_hi + EXT_W'(1);
        wrap_nxt   = 1'b1;
        if (ext_hi == EXT_MAX) begin
          ovf_nxt = 1'b1;
        end
      end
      if (bad_step) begin
        err_nxt = 1'b1;
      end
    end
    eq_nxt = ({ext_hi_nxt, cnt_in} == cmp_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      ext_hi  <= '0;
      primed  <= 1'b0;
      wrap    <= 1'b0;
      ovf     <= 1'b0;
      seq_err <= 1'b0;
      eq_q    <= 1'b0;
      match   <= 1'b0;
    end else begin
      cnt_q   <= cnt_in;
      ext_hi  <= ext_hi_nxt;
      primed  <= 1'b1;
      wrap    <= wrap_nxt;
      ovf     <= ovf_nxt;
      seq_err <= err_nxt;
      eq_q    <= clr ? 1'b0 : eq_nxt;
      match   <= eq_nxt & ~eq_q;
    end
  end

  assign ext_cnt = {ext_hi, cnt_q};

  // Snapshot FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state <= CAP_IDLE;
      cap_data  <= '0;
    end else begin
      cap_state <= cap_state_nxt;
      cap_data  <= cap_data_nxt;
    end
  end

  // Requests are only honoured in IDLE; the snapshot is frozen while held.
  always_comb begin
    cap_state_nxt = cap_state;
    cap_data_nxt  = cap_data;
    case (cap_state)
      CAP_IDLE: begin
        if (cap_req) begin
          cap_data_nxt  = ext_cnt;
          cap_state_nxt = CAP_HOLD;
        end
      end
      CAP_HOLD: begin
        if (cap_ready) begin
          cap_state_nxt = CAP_IDLE;
        end
      end
      default: cap_state_nxt = CAP_IDLE;
    endcase
  end

  assign cap_valid = (cap_state == CAP_HOLD);

endmodule

// File: tb/tb_count_extender.sv
// Scoreboard bench for count_extender (EXT_W=2); ovf expectation follows COUNT_EXT_OVF_STICKY_EN.
module tb_count_extender;
  import count_pkg::*;

  localparam int unsigned EXT_W = 2;
  localparam int unsigned TW    = CNT_W + EXT_W;

  localparam logic [6:0] M_EXT   = 7'h01;
  localparam logic [6:0] M_WRAP  = 7'h02;
  localparam logic [6:0] M_MATCH = 7'h04;
  localparam logic [6:0] M_OVF   = 7'h08;
  localparam logic [6:0] M_ERR   = 7'h10;
  localparam logic [6:0] M_CV    = 7'h20;
  localparam logic [6:0] M_CD    = 7'h40;
  localparam logic [6:0] M_BASE  = M_EXT | M_WRAP | M_OVF | M_ERR | M_CV;
  localparam logic [6:0] M_ALL   = 7'h7F;

`ifdef COUNT_EXT_OVF_STICKY_EN
  localparam int OVF_AFTER = 1;
`else
  localparam int OVF_AFTER = 0;
`endif

  typedef struct {
    logic [TW-1:0] ext;
    logic          wrap;
    logic          match;
    logic          ovf;
    logic          err;
    logic          cv;
    logic [TW-1:0] cd;
    logic [6:0]    mask;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] cnt_in;
  logic             clr;
  logic [TW-1:0]    cmp_val;
  logic [TW-1:0]    ext_cnt;
  logic             wrap;
  logic             match;
  logic             ovf;
  logic             seq_err;
  logic             cap_req;
  logic             cap_valid;
  logic             cap_ready;
  logic [TW-1:0]    cap_data;

  exp_t  sb_q[$];
  string nm_q[$];
  exp_t  mon_x;
  string mon_nm;
  int    checks = 0;
  int    errors = 0;

  count_extender #(.EXT_W(EXT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .cmp_val   (cmp_val),
    .ext_cnt   (ext_cnt),
    .wrap      (wrap),
    .match     (match),
    .ovf       (ovf),
    .seq_err   (seq_err),
    .cap_req   (cap_req),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .cap_data  (cap_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string f, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", nm, f, act, exp);
    end
  endtask

  // Clock the current inputs in and queue the outputs expected after this edge.
  task automatic tick(input string nm, input int ext, input int w, input int m, input int o,
                      input int e, input int cv, input int cd, input logic [6:0] mask);
    exp_t x;
    @(posedge clk);
    x.ext   = TW'(ext);
    x.wrap  = (w != 0);
    x.match = (m != 0);
    x.ovf   = (o != 0);
    x.err   = (e != 0);
    x.cv    = (cv != 0);
    x.cd    = TW'(cd);
    x.mask  = mask;
    sb_q.push_back(x);
    nm_q.push_back(nm);
    #1;
  endtask

  // Monitor: compare one queued expectation per cycle, mid-period.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_x  = sb_q.pop_front();
        mon_nm = nm_q.pop_front();
        if (mon_x.mask[0]) chk(mon_nm, "ext_cnt",   32'(ext_cnt),   32'(mon_x.ext));
        if (mon_x.mask[1]) chk(mon_nm, "wrap",      32'(wrap),      32'(mon_x.wrap));
        if (mon_x.mask[2]) chk(mon_nm, "match",     32'(match),     32'(mon_x.match));
        if (mon_x.mask[3]) chk(mon_nm, "ovf",       32'(ovf),       32'(mon_x.ovf));
        if (mon_x.mask[4]) chk(mon_nm, "seq_err",   32'(seq_err),   32'(mon_x.err));
        if (mon_x.mask[5]) chk(mon_nm, "cap_valid", 32'(cap_valid), 32'(mon_x.cv));
        if (mon_x.mask[6]) chk(mon_nm, "cap_data",  32'(cap_data),  32'(mon_x.cd));
      end
    end
  end

  initial begin
    reset = 1'b1; cnt_in = '0; clr = 1'b0; cmp_val = 6'h3F; cap_req = 1'b0; cap_ready = 1'b0;
    #1;
    tick("rst0", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    tick("rst1", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    reset = 1'b0;

    // Two full wraps then 0,1.
    for (int w = 0; w < 2; w++) begin
      for (int v = 0; v < 16; v++) begin
        cnt_in = 4'(v);
        tick("count", w * 16 + v, int'(w > 0 && v == 0), 0, 0, 0, 0, 0, M_BASE);
      end
    end
    cnt_in = 4'd0; tick("wrap2", 6'h20, 1, 0, 0, 0, 0, 0, M_BASE);
    cnt_in = 4'd1; tick("final", 6'h21, 0, 0, 0, 0, 0, 0, M_BASE);

    // Continue to the fourth wrap, which overflows the 2-bit extension.
    for (int v = 2; v < 16; v++) begin
      cnt_in = 4'(v); tick("to_w3", 32 + v, 0, 0, 0, 0, 0, 0, M_BASE);
    end
    cnt_in = 4'd0; tick("wrap3", 6'h30, 1, 0, 0, 0, 0, 0, M_BASE);
    for (int v = 1; v < 16; v++) begin
      cnt_in = 4'(v); tick("to_w4", 48 + v, 0, 0, 0, 0, 0, 0, M_BASE);
    end
    cnt_in = 4'd0; tick("ovf_wrap", 6'h00, 1, 0, 1, 0, 0, 0, M_BASE);
    cnt_in = 4'd1; tick("ovf_after1", 6'h01, 0, 0, OVF_AFTER, 0, 0, 0, M_BASE);
    cnt_in = 4'd2; tick("ovf_after2", 6'h02, 0, 0, OVF_AFTER, 0, 0, 0, M_BASE);
    cnt_in = 4'd3; tick("ovf_after3", 6'h03, 0, 0, OVF_AFTER, 0, 0, 0, M_BASE);
    clr = 1'b1; cnt_in = 4'd4; tick("ovf_clr", 6'h04, 0, 0, 0, 0, 0, 0, M_BASE);
    clr = 1'b0; cnt_in = 4'd5; tick("post_clr", 6'h05, 0, 0, 0, 0, 0, 0, M_BASE);

    // Illegal steps; first post-reset sample must not be classified.
    reset = 1'b1; cnt_in = 4'd9; tick("rst_seq", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    reset = 1'b0; cnt_in = 4'd2; tick("prime", 6'h02, 0, 0, 0, 0, 0, 0, M_BASE);
    cnt_in = 4'd3; tick("s3", 6'h03, 0, 0, 0, 0, 0, 0, M_BASE);
    cnt_in = 4'd7; tick("jump", 6'h07, 0, 0, 0, 1, 0, 0, M_BASE);
    cnt_in = 4'd8; tick("err_stk8", 6'h08, 0, 0, 0, 1, 0, 0, M_BASE);
    cnt_in = 4'd9; tick("err_stk9", 6'h09, 0, 0, 0, 1, 0, 0, M_BASE);
    clr = 1'b1; cnt_in = 4'd10; tick("err_clr", 6'h0A, 0, 0, 0, 0, 0, 0, M_BASE);
    clr = 1'b0; cnt_in = 4'd11; tick("s11", 6'h0B, 0, 0, 0, 0, 0, 0, M_BASE);
    tick("hold11", 6'h0B, 0, 0, 0, 0, 0, 0, M_BASE);
    for (int v = 12; v < 16; v++) begin
      cnt_in = 4'(v); tick("to15", v, 0, 0, 0, 0, 0, 0, M_BASE);
    end
    clr = 1'b1; cnt_in = 4'd0; tick("clr_wrap", 6'h00, 0, 0, 0, 0, 0, 0, M_BASE);
    clr = 1'b0; cnt_in = 4'd1; tick("after_cw", 6'h01, 0, 0, 0, 0, 0, 0, M_BASE);
    for (int v = 2; v < 16; v++) begin
      cnt_in = 4'(v); tick("to15b", v, 0, 0, 0, 0, 0, 0, M_BASE);
    end
    cnt_in = 4'd5; tick("bad_from15", 6'h05, 0, 0, 0, 1, 0, 0, M_BASE);
    clr = 1'b1; cnt_in = 4'd6; tick("err_clr2", 6'h06, 0, 0, 0, 0, 0, 0, M_BASE);
    clr = 1'b0;

    // Compare match: rising edge of equality only.
    reset = 1'b1; cmp_val = 6'h13; cnt_in = 4'd0; tick("rst_m", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    reset = 1'b0;
    for (int v = 0; v < 16; v++) begin
      cnt_in = 4'(v); tick("m_cnt", v, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    end
    cnt_in = 4'd0; tick("m_10", 6'h10, 1, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    cnt_in = 4'd1; tick("m_11", 6'h11, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    cnt_in = 4'd2; tick("m_12", 6'h12, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    cnt_in = 4'd3; tick("m_hit", 6'h13, 0, 1, 0, 0, 0, 0, M_BASE | M_MATCH);
    for (int i = 0; i < 4; i++) begin
      tick("m_hold", 6'h13, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    end
    cnt_in = 4'd4; tick("m_14", 6'h14, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);
    cmp_val = 6'h14; tick("m_cmpchg", 6'h14, 0, 1, 0, 0, 0, 0, M_BASE | M_MATCH);
    tick("m_cmphold", 6'h14, 0, 0, 0, 0, 0, 0, M_BASE | M_MATCH);

    // Capture handshake.
    reset = 1'b1; cmp_val = 6'h3F; cnt_in = 4'd0; tick("rst_c", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    reset = 1'b0;
    for (int v = 0; v < 6; v++) begin
      cnt_in = 4'(v); tick("c_cnt", v, 0, 0, 0, 0, 0, 0, M_BASE | M_CD);
    end
    cap_req = 1'b1; cnt_in = 4'd6; tick("cap_take", 6'h06, 0, 0, 0, 0, 1, 6'h05, M_BASE | M_CD);
    cap_req = 1'b0;
    for (int v = 7; v < 10; v++) begin
      cnt_in = 4'(v); tick("cap_hold", v, 0, 0, 0, 0, 1, 6'h05, M_BASE | M_CD);
    end
    cap_req = 1'b1; cap_ready = 1'b1; cnt_in = 4'd10;
    tick("cap_done", 6'h0A, 0, 0, 0, 0, 0, 6'h05, M_BASE | M_CD);
    cap_req = 1'b0; cap_ready = 1'b0; cnt_in = 4'd11;
    tick("cap_idle", 6'h0B, 0, 0, 0, 0, 0, 6'h05, M_BASE | M_CD);
    cap_req = 1'b1; cnt_in = 4'd12; tick("cap_again", 6'h0C, 0, 0, 0, 0, 1, 6'h0B, M_BASE | M_CD);
    cap_req = 1'b0;

    // Count on to 0x2A while holding, then reset mid-capture.
    for (int n = 13; n <= 42; n++) begin
      cnt_in = 4'(n % 16);
      tick("c_run", n, int'(n % 16 == 0), 0, 0, 0, 1, 6'h0B, M_BASE | M_CD);
    end
    reset = 1'b1; cnt_in = 4'd11; tick("rst_hold", 0, 0, 0, 0, 0, 0, 0, M_ALL);
    reset = 1'b0; tick("first_smp", 6'h0B, 0, 0, 0, 0, 0, 0, M_BASE | M_CD);
    cnt_in = 4'd12; tick("next_smp", 6'h0C, 0, 0, 0, 0, 0, 0, M_BASE | M_CD);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
